// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared types and one-hot helpers for the vote capture front-end
package voting_pkg;

  localparam int NUM_CANDIDATES = 4;
  localparam int IDX_W          = 2;

  typedef logic [NUM_CANDIDATES-1:0] btn_t;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    COMMIT,
    RELEASE,
    LOCKOUT
  } state_e;

  function automatic logic is_onehot(input btn_t v);
    return (v != '0) && ((v & (v - btn_t'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input btn_t v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_capture_controller_if.sv
// rtl/vote_capture_controller_if.sv - button inputs, tallies and strobes of the vote front-end
interface vote_capture_controller_if #(
  parameter int CNT_W = 8
);
  logic             mode;
  logic             clear_counts;
  logic             button0;
  logic             button1;
  logic             button2;
  logic             button3;
  logic [CNT_W-1:0] candidate_vote0;
  logic [CNT_W-1:0] candidate_vote1;
  logic [CNT_W-1:0] candidate_vote2;
  logic [CNT_W-1:0] candidate_vote3;
  logic             valid_vote_casted;
  logic             invalid_vote;
  logic             busy;

  modport master (
    output mode, clear_counts, button0, button1, button2, button3,
    input  candidate_vote0, candidate_vote1, candidate_vote2, candidate_vote3,
    input  valid_vote_casted, invalid_vote, busy
  );

  modport slave (
    input  mode, clear_counts, button0, button1, button2, button3,
    output candidate_vote0, candidate_vote1, candidate_vote2, candidate_vote3,
    output valid_vote_casted, invalid_vote, busy
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear taking priority
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vote_capture_controller.sv
// rtl/vote_capture_controller.sv - debounces candidate buttons and commits one vote per clean press
module vote_capture_controller
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 10,
  parameter int CNT_W           = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  vote_capture_controller_if.slave  bus
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  state_e            state_q, state_d;
  btn_t              btn_q;
  btn_t              sel_q, sel_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              valid_q, valid_d;
  logic              invalid_q, invalid_d;
  logic [IDX_W-1:0]  commit_idx;
  logic [CNT_W-1:0]  tally [NUM_CANDIDATES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      btn_q      <= '0;
      sel_q      <= '0;
      deb_cnt_q  <= '0;
      lock_cnt_q <= '0;
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= {bus.button3, bus.button2, bus.button1, bus.button0};
      sel_q      <= sel_d;
      deb_cnt_q  <= deb_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      valid_q    <= valid_d;
      invalid_q  <= invalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    deb_cnt_d  = deb_cnt_q;
    lock_cnt_d = lock_cnt_q;
    valid_d    = 1'b0;
    invalid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.mode && (btn_q != '0)) begin
          sel_d     = btn_q;
          deb_cnt_d = '0;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change of pattern restarts from IDLE rather than re-arming in place.
        if (bus.mode || (btn_q != sel_q)) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          if (is_onehot(sel_q)) begin
            state_d = COMMIT;
          end else begin
            state_d   = RELEASE;
            invalid_d = 1'b1;
          end
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      COMMIT: begin
        state_d = RELEASE;
        valid_d = 1'b1;
      end
      RELEASE: begin
        if (btn_q == '0) begin
          lock_cnt_d = '0;
          state_d    = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit_idx = onehot_to_idx(sel_q);

  // Tallies bump on the same edge that raises valid_vote_casted (leaving COMMIT).
  for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_tally
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc_i   ((state_q == COMMIT) && (commit_idx == IDX_W'(g))),
      .clr_i   (bus.clear_counts),
      .count_o (tally[g])
    );
  end

  assign bus.candidate_vote0   = tally[0];
  assign bus.candidate_vote1   = tally[1];
  assign bus.candidate_vote2   = tally[2];
  assign bus.candidate_vote3   = tally[3];
  assign bus.valid_vote_casted = valid_q;
  assign bus.invalid_vote      = invalid_q;
  assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_vote_capture_controller.sv
// tb/tb_vote_capture_controller.sv - randomized and directed bench against a press-level vote model
module tb_vote_capture_controller;

  localparam int DEB  = 4;
  localparam int LOCK = 10;
  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  vote_capture_controller_if #(.CNT_W(CW)) bus ();

  vote_capture_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK),
    .CNT_W           (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0;
  int n_invalid = 0;
  int last_valid_cyc = -1;

  // Press-level model: which press is being qualified, whether a vote is owed,
  // whether we wait for release, and how many lockout edges remain.
  int         m_tally [4];
  logic [3:0] m_btn;
  logic [3:0] m_sel;
  int         m_held;
  bit         m_commit;
  int         m_cand;
  bit         m_release;
  int         m_lock;
  bit         e_valid;
  bit         e_invalid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tally[i] = 0;
    m_btn = '0; m_sel = '0; m_held = 0; m_commit = 0; m_cand = 0;
    m_release = 0; m_lock = 0; e_valid = 0; e_invalid = 0;
  endtask

  task automatic model_step();
    logic [3:0] now_btn;
    now_btn   = {bus.button3, bus.button2, bus.button1, bus.button0};
    e_valid   = 0;
    e_invalid = 0;
    if (m_lock > 0) begin
      m_lock--;
    end else if (m_release) begin
      if (m_btn == 0) begin
        m_release = 0;
        m_lock    = LOCK;
      end
    end else if (m_commit) begin
      if (m_tally[m_cand] < MAXV) m_tally[m_cand]++;
      e_valid   = 1;
      m_commit  = 0;
      m_release = 1;
    end else if (m_sel != 0) begin
      if (bus.mode || (m_btn != m_sel)) begin
        m_sel = 0;
      end else if (m_held == DEB - 1) begin
        if ($countones(m_sel) == 1) begin
          m_commit = 1;
          m_cand   = $clog2(m_sel);
        end else begin
          e_invalid = 1;
          m_release = 1;
        end
        m_sel = 0;
      end else begin
        m_held++;
      end
    end else if (!bus.mode && (m_btn != 0)) begin
      m_sel  = m_btn;
      m_held = 0;
    end
    if (bus.clear_counts) for (int i = 0; i < 4; i++) m_tally[i] = 0;
    m_btn = now_btn;
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (reset) model_step();
    else model_reset();
    @(negedge clock);
    check("vote0", bus.candidate_vote0, m_tally[0]);
    check("vote1", bus.candidate_vote1, m_tally[1]);
    check("vote2", bus.candidate_vote2, m_tally[2]);
    check("vote3", bus.candidate_vote3, m_tally[3]);
    check("valid", bus.valid_vote_casted, e_valid);
    check("invalid", bus.invalid_vote, e_invalid);
    check("busy", bus.busy, (m_lock > 0) || m_release || m_commit || (m_sel != 0));
    if (bus.valid_vote_casted) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (bus.invalid_vote) n_invalid++;
  endtask

  task automatic set_btn(input logic [3:0] p);
    bus.button0 = p[0];
    bus.button1 = p[1];
    bus.button2 = p[2];
    bus.button3 = p[3];
  endtask

  task automatic press(input logic [3:0] p, input int hold);
    set_btn(p);
    repeat (hold) tick();
    set_btn(4'b0000);
  endtask

  task automatic vote(input logic [3:0] p);
    press(p, DEB + 4);
    repeat (LOCK + 3) tick();
  endtask

  task automatic wait_commit();
    for (int k = 0; k < 40 && !m_commit; k++) tick();
    check("commit_wait", m_commit, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int nv;
    bus.mode = 1'b0;
    bus.clear_counts = 1'b0;
    set_btn(4'b0000);
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_vote0", bus.candidate_vote0, 0);
    check("rst_vote1", bus.candidate_vote1, 0);
    check("rst_valid", bus.valid_vote_casted, 0);
    check("rst_invalid", bus.invalid_vote, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Clean single press of button1.
    c = cyc; n_valid = 0; last_valid_cyc = -1;
    press(4'b0010, 20);
    check("s1_latency", last_valid_cyc - c, DEB + 3);
    check("s1_pulses", n_valid, 1);
    check("s1_vote1", bus.candidate_vote1, 1);
    repeat (LOCK + 2) tick();
    check("s1_busy_after_lock", bus.busy, 0);

    // Too-short press.
    press(4'b0001, 2);
    repeat (4) tick();
    check("s2_vote0", bus.candidate_vote0, 0);
    check("s2_busy", bus.busy, 0);
    check("s2_pulses", n_valid, 1);

    // Two-button press rejected, then a lone button3 counts.
    n_invalid = 0;
    press(4'b1100, 10);
    check("s3_invalid_once", n_invalid, 1);
    check("s3_vote2", bus.candidate_vote2, 0);
    check("s3_vote3", bus.candidate_vote3, 0);
    repeat (LOCK + 2) tick();
    vote(4'b1000);
    check("s3_vote3_after", bus.candidate_vote3, 1);

    // Press during lockout is ignored, after lockout counts.
    press(4'b0001, 10);
    repeat (3) tick();
    press(4'b0001, 6);
    repeat (LOCK + 4) tick();
    check("s4_vote0_lockout", bus.candidate_vote0, 1);
    vote(4'b0001);
    check("s4_vote0_second", bus.candidate_vote0, 2);

    // Saturation of candidate 2.
    for (int i = 0; i < MAXV; i++) vote(4'b0100);
    check("s5_vote2_full", bus.candidate_vote2, MAXV);
    nv = n_valid;
    vote(4'b0100);
    check("s5_sat_pulse", n_valid, nv + 1);
    check("s5_vote2_hold", bus.candidate_vote2, MAXV);

    // clear_counts coinciding with the commit edge.
    set_btn(4'b0001);
    wait_commit();
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    check("s5_clr_pulse", bus.valid_vote_casted, 1);
    check("s5_clr_vote0", bus.candidate_vote0, 0);
    check("s5_clr_vote2", bus.candidate_vote2, 0);
    check("s5_clr_vote3", bus.candidate_vote3, 0);
    set_btn(4'b0000);
    repeat (LOCK + 3) tick();

    // mode rising during debounce aborts.
    nv = n_valid;
    set_btn(4'b0010);
    repeat (3) tick();
    bus.mode = 1'b1;
    repeat (6) tick();
    check("s6_abort_pulses", n_valid, nv);
    check("s6_abort_vote1", bus.candidate_vote1, 0);
    set_btn(4'b0000);
    bus.mode = 1'b0;
    repeat (3) tick();

    // Asynchronous reset while in COMMIT.
    vote(4'b0010);
    check("s6_vote1", bus.candidate_vote1, 1);
    set_btn(4'b0100);
    wait_commit();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("s6_rst_vote1", bus.candidate_vote1, 0);
    check("s6_rst_valid", bus.valid_vote_casted, 0);
    check("s6_rst_busy", bus.busy, 0);
    set_btn(4'b0000);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) tick();
    check("s6_post_rst_pulses", bus.valid_vote_casted, 0);

    // Randomized presses, mode toggles and clears.
    for (int i = 0; i < 150; i++) begin
      bus.mode = ($urandom_range(0, 7) == 0);
      bus.clear_counts = ($urandom_range(0, 15) == 0);
      set_btn(4'($urandom_range(0, 15)));
      tick();
      bus.clear_counts = 1'b0;
      repeat ($urandom_range(0, 13)) tick();
      set_btn(4'b0000);
      bus.mode = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 15)) tick();
    end
    bus.mode = 1'b0;
    repeat (LOCK + 4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
